regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (reg_write / w_reg / w_data) between NUM_REQ write-back requesters, e.g. ALU, load unit and CSR unit.
- Keeps a destination scoreboard (one busy bit per architectural register) so the issue stage can detect RAW hazards on pending writes.
- Sits between the execute/memory stages and the register file.
- Drives the write port from registers on the rising edge; the register file captures on the falling edge.

Parameters:
- NUM_REQ, 3, number of write-back requesters; index 0 has the highest fixed priority.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers and scoreboard bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero, combinational.
- req_addr  in  NUM_REQ*ADDR_W  packed destination registers; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- wb_hold  in  1  forces all req_ready low while high.
- mark_valid  in  1  issue stage reserves a destination register.
- mark_addr  in  ADDR_W  register being reserved.
- flush  in  1  synchronous clear of every scoreboard bit.
- query_addr1  in  ADDR_W  source operand 1 to check.
- query_addr2  in  ADDR_W  source operand 2 to check.
- query_busy1  out  1  busy[query_addr1], combinational.
- query_busy2  out  1  busy[query_addr2], combinational.
- busy_mask  out  NUM_REGS  full scoreboard, registered.
- reg_write  out  1  register file write enable, registered.
- w_reg  out  ADDR_W  register file write address, registered.
- w_data  out  DATA_W  register file write data, registered.

Behaviour:
- Reset (reset low, asynchronous):
  - reg_write=0, w_reg=0, w_data=0, busy_mask=0, RR pointer=0.
  - req_ready is 0 while reset is low.
  - In-flight requests are dropped; requesters re-present them after reset.
- Handshake:
  - A transfer happens on a rising edge with req_valid[i] & req_ready[i].
  - At most one grant per cycle.
  - A requester holds valid, addr and data stable until it sees ready.
  - req_ready[i] never asserts unless req_valid[i] is high.
- Arbitration (RR_ARB_EN defined):
  - Search starts at the pointer, increasing index, wrapping at NUM_REQ-1 -> 0.
  - On a transfer the pointer becomes (winner+1) mod NUM_REQ; otherwise it holds.
- wb_hold=1: no grants, pointer holds, reg_write=0 on the next edge.
- Latency:
  - A transfer on edge N drives reg_write=1 with w_reg/w_data from edge N for one cycle.
  - The register file writes on the following falling edge.
  - With no transfer, reg_write=0 and w_reg/w_data hold their last values.
- x0 handling:
  - A request to address 0 is granted normally (ready=1).
  - reg_write stays 0 and the scoreboard is untouched.
- Scoreboard:
  - mark_valid sets busy[mark_addr]; a transfer clears busy[req_addr] on the same edge.
  - Simultaneous mark and clear of the same address: mark wins, busy stays 1 (new producer).
  - flush clears all bits and overrides mark on the same edge.
  - busy[0] is constant 0.
  - Marking an already-busy register leaves it busy; no count is kept.
- Query:
  - Purely combinational from the current busy register; no bypass of same-cycle clears.
  - query_addr 0 always returns 0.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins; the pointer register is not instantiated.
- Starvation of high indices is then accepted by design.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN=32, REG_ADDR_W=5, NUM_REGS=32;
  - typedef wb_req_t {logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data;};
  - typedef busy_vec_t (NUM_REGS bits).
- One sub-module, wb_rr_arbiter: request vector in, one-hot grant out, pointer state inside, honours RR_ARB_EN.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset: hold reset low for 3 cycles with all req_valid=1 -> reg_write=0, busy_mask=0, req_ready=0; release -> first grant goes to requester 0.
- Single write: req 1 valid, addr=5, data=32'hDEADBEEF -> ready[1]=1 for one cycle; next cycle reg_write=1, w_reg=5, w_data=32'hDEADBEEF; cycle after, reg_write=0.
- Contention (RR_ARB_EN): all 3 valid for 6 cycles, addrs 1/2/3 -> grant order 0,1,2,0,1,2.
  - Without RR_ARB_EN -> requester 0 granted all 6 cycles.
- Scoreboard: mark addr 7 -> query_busy1(7)=1 next cycle; write to 7 granted -> busy clears on that edge.
  - Mark 7 and write 7 on the same edge -> busy[7] stays 1.
- x0 and hold: request addr 0 -> ready=1, reg_write stays 0.
  - wb_hold=1 with req 2 valid -> ready=0 and pointer unchanged; release -> req 2 granted.
- Flush: busy_mask=32'h0000_00F0, assert flush with mark_addr=9 -> busy_mask=0.
  - Assert reset mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and payload types for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef logic [NUM_REGS-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back requester bundle: packed per-requester valid/ready/addr/data plus a global hold.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = XLEN
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wb_hold;

  modport master (
    output req_valid, req_addr, req_data, wb_hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, wb_hold,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_arb.sv
// One-hot grant selection for the write-back port.
// RR_ARB_EN selects round-robin with a rotating pointer; otherwise fixed priority, index 0 first.
module wb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef RR_ARB_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] winner_c;
  logic             found_c;

  // Scan from the pointer upward, wrapping past the last requester.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant    = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_c && req[idx]) begin
        found_c  = 1'b1;
        winner_c = PTR_W'(idx);
      end
    end
    if (found_c) grant[winner_c] = 1'b1;
  end

  always_comb begin
    ptr_nxt = ptr_q;
    if (found_c) begin
      if (32'(winner_c) == NUM_REQ - 1) ptr_nxt = '0;
      else                              ptr_nxt = winner_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_nxt;
  end
`else
  logic found_c;
  logic unused_clk_reset;

  // Clock and reset only feed the pointer, which fixed priority does not need.
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    grant   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && req[i]) begin
        found_c  = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ write-back sources and tracks pending
// destinations in a busy scoreboard. Arbitration policy selected by RR_ARB_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned DATA_W   = XLEN,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic                mark_valid,
  input  logic [ADDR_W-1:0]   mark_addr,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   query_addr1,
  input  logic [ADDR_W-1:0]   query_addr2,
  output logic                query_busy1,
  output logic                query_busy2,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   w_reg,
  output logic [DATA_W-1:0]   w_data
);

  logic [NUM_REQ-1:0]  req_eligible_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                transfer_c;
  logic                write_c;
  logic [NUM_REGS-1:0] busy_nxt_c;

  assign req_eligible_c = wb.req_valid & {NUM_REQ{~wb.wb_hold}};

  wb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_eligible_c),
    .grant (grant_c)
  );

  // Grants are suppressed combinationally while reset is asserted.
  assign wb.req_ready = grant_c & {NUM_REQ{reset}};

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wb.req_ready[i]) begin
        sel_addr_c = wb.req_addr[i*ADDR_W +: ADDR_W];
        sel_data_c = wb.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer_c = |wb.req_ready;
  // x0 requests complete the handshake but never reach the register file.
  assign write_c    = transfer_c && (sel_addr_c != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      w_reg     <= '0;
      w_data    <= '0;
    end else begin
      reg_write <= write_c;
      if (write_c) begin
        w_reg  <= sel_addr_c;
        w_data <= sel_data_c;
      end
    end
  end

  // Priority: retire-clear < new mark < flush; entry 0 never busy.
  always_comb begin
    busy_nxt_c = busy_mask;
    if (write_c)    busy_nxt_c[sel_addr_c] = 1'b0;
    if (mark_valid) busy_nxt_c[mark_addr]  = 1'b1;
    if (flush)      busy_nxt_c             = '0;
    busy_nxt_c[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_mask <= '0;
    else        busy_mask <= busy_nxt_c;
  end

  assign query_busy1 = busy_mask[query_addr1];
  assign query_busy2 = busy_mask[query_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected write-port transactions are queued as grants
// are checked, and a negedge monitor compares them against reg_write/w_reg/w_data.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned NREQ = 3;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  mark_valid;
  logic [REG_ADDR_W-1:0] mark_addr;
  logic                  flush;
  logic [REG_ADDR_W-1:0] query_addr1;
  logic [REG_ADDR_W-1:0] query_addr2;
  logic                  query_busy1;
  logic                  query_busy2;
  busy_vec_t             busy_mask;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] w_reg;
  logic [XLEN-1:0]       w_data;

  regfile_wb_arbiter_if #(.NUM_REQ(NREQ)) wb_if ();

  regfile_wb_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb_if.slave),
    .mark_valid  (mark_valid),
    .mark_addr   (mark_addr),
    .flush       (flush),
    .query_addr1 (query_addr1),
    .query_addr2 (query_addr2),
    .query_busy1 (query_busy1),
    .query_busy2 (query_busy2),
    .busy_mask   (busy_mask),
    .reg_write   (reg_write),
    .w_reg       (w_reg),
    .w_data      (w_data)
  );

  always #5 clk = ~clk;

  int      n_chk  = 0;
  int      n_fail = 0;
  wb_req_t exp_q[$];
  wb_req_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    wb_if.req_addr[i*REG_ADDR_W +: REG_ADDR_W] = a;
    wb_if.req_data[i*XLEN +: XLEN]             = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && reg_write) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got w_reg=%0d w_data=0x%08h expected no write", w_reg, w_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_reg", 32'(w_reg), 32'(mon_e.addr));
        chk("wb_data", w_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    wb_if.req_valid = '0;
    wb_if.req_addr  = '0;
    wb_if.req_data  = '0;
    wb_if.wb_hold   = 1'b0;
    mark_valid      = 1'b0;
    mark_addr       = '0;
    flush           = 1'b0;
    query_addr1     = '0;
    query_addr2     = '0;
    #1 reset = 1'b0;

    // Reset with all requesters pending
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hB000_0001);
    set_req(2, 5'd3, 32'hC000_0002);
    wb_if.req_valid = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(wb_if.req_ready), 32'h0);
    chk("rst_reg_write", 32'(reg_write), 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_w_reg", 32'(w_reg), 32'h0);
    chk("rst_w_data", w_data, 32'h0);
    step();
    reset = 1'b1;

    // Contention: three requesters held valid for six cycles
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      w = RR ? (k % 3) : 0;
      chk("contend_grant", 32'(wb_if.req_ready), 32'(1 << w));
      push(5'(w + 1), (w == 0) ? 32'hA000_0000 : (w == 1) ? 32'hB000_0001 : 32'hC000_0002);
      step();
    end
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("idle_ready", 32'(wb_if.req_ready), 32'h0);
    step();
    @(negedge clk);
    chk("idle_reg_write", 32'(reg_write), 32'h0);
    chk("idle_w_reg_hold", 32'(w_reg), RR ? 32'd3 : 32'd1);

    // Single write from requester 1
    step();
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    wb_if.req_valid = 3'b010;
    @(negedge clk);
    chk("single_ready", 32'(wb_if.req_ready), 32'h2);
    push(5'd5, 32'hDEAD_BEEF);
    step();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("single_ready_drop", 32'(wb_if.req_ready), 32'h0);
    step();
    @(negedge clk);
    chk("single_reg_write_off", 32'(reg_write), 32'h0);

    // Scoreboard mark then retire
    step();
    mark_valid  = 1'b1;
    mark_addr   = 5'd7;
    query_addr1 = 5'd7;
    @(negedge clk);
    chk("sb_before_mark", 32'(query_busy1), 32'h0);
    step();
    mark_valid = 1'b0;
    @(negedge clk);
    chk("sb_marked_q1", 32'(query_busy1), 32'h1);
    chk("sb_marked_mask", busy_mask, 32'h0000_0080);
    step();
    set_req(0, 5'd7, 32'h7777_0001);
    wb_if.req_valid = 3'b001;
    @(negedge clk);
    chk("sb_retire_ready", 32'(wb_if.req_ready), 32'h1);
    chk("sb_no_bypass", 32'(query_busy1), 32'h1);
    push(5'd7, 32'h7777_0001);
    step();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("sb_retired_mask", busy_mask, 32'h0);
    chk("sb_retired_q1", 32'(query_busy1), 32'h0);

    // Mark and retire of the same register on one edge: mark wins
    step();
    mark_valid = 1'b1;
    mark_addr  = 5'd7;
    set_req(0, 5'd7, 32'h7777_0002);
    wb_if.req_valid = 3'b001;
    @(negedge clk);
    chk("sb_same_ready", 32'(wb_if.req_ready), 32'h1);
    push(5'd7, 32'h7777_0002);
    step();
    mark_valid      = 1'b0;
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("sb_same_edge_mask", busy_mask, 32'h0000_0080);

    // Flush overrides a same-edge mark
    for (int a = 4; a < 7; a++) begin
      step();
      mark_valid = 1'b1;
      mark_addr  = 5'(a);
    end
    step();
    mark_valid  = 1'b0;
    query_addr2 = 5'd5;
    @(negedge clk);
    chk("flush_pre_mask", busy_mask, 32'h0000_00F0);
    chk("flush_pre_q2", 32'(query_busy2), 32'h1);
    step();
    flush      = 1'b1;
    mark_valid = 1'b1;
    mark_addr  = 5'd9;
    step();
    flush       = 1'b0;
    mark_valid  = 1'b0;
    query_addr2 = 5'd0;
    @(negedge clk);
    chk("flush_mask", busy_mask, 32'h0);
    chk("flush_q2_x0", 32'(query_busy2), 32'h0);

    // Write to x0: handshake completes, no register write
    step();
    set_req(2, 5'd0, 32'h0000_1234);
    wb_if.req_valid = 3'b100;
    @(negedge clk);
    chk("x0_ready", 32'(wb_if.req_ready), 32'h4);
    step();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("x0_reg_write", 32'(reg_write), 32'h0);
    chk("x0_busy", busy_mask, 32'h0);

    // Hold blocks grants until released
    step();
    wb_if.wb_hold = 1'b1;
    set_req(2, 5'd10, 32'hAAAA_000A);
    wb_if.req_valid = 3'b100;
    @(negedge clk);
    chk("hold_ready", 32'(wb_if.req_ready), 32'h0);
    step();
    @(negedge clk);
    chk("hold_reg_write", 32'(reg_write), 32'h0);
    step();
    wb_if.wb_hold = 1'b0;
    @(negedge clk);
    chk("hold_release_ready", 32'(wb_if.req_ready), 32'h4);
    push(5'd10, 32'hAAAA_000A);
    step();
    wb_if.req_valid = '0;
    @(negedge clk);

    // Reset arriving while a write is on the port
    step();
    set_req(1, 5'd11, 32'hBBBB_000B);
    wb_if.req_valid = 3'b010;
    mark_valid      = 1'b1;
    mark_addr       = 5'd12;
    @(negedge clk);
    chk("mid_ready", 32'(wb_if.req_ready), 32'h2);
    step();
    mark_valid = 1'b0;
    chk("mid_reg_write", 32'(reg_write), 32'h1);
    chk("mid_w_reg", 32'(w_reg), 32'd11);
    chk("mid_busy", busy_mask, 32'h0000_1000);
    reset = 1'b0;
    #1;
    chk("mid_rst_reg_write", 32'(reg_write), 32'h0);
    chk("mid_rst_w_reg", 32'(w_reg), 32'h0);
    chk("mid_rst_w_data", w_data, 32'h0);
    chk("mid_rst_busy", busy_mask, 32'h0);
    chk("mid_rst_ready", 32'(wb_if.req_ready), 32'h0);
    step();
    step();
    wb_if.req_valid = '0;
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
